// File: rtl/fp_normalize16_pipe_pkg.sv
// Shared FP16 normalizer types and constants: the FP16N output word,
// the FP16U unpacked operand, and the exponent-field limits.
package fp16Pkg;

  localparam int unsigned EMSB = 4;
  localparam int unsigned FMSB = 12;
  localparam int          BIAS = 15;

  localparam logic [EMSB:0] EXP_MAX  = 5'(2 * BIAS + 1);
  localparam logic [FMSB:0] QNAN_SIG = 13'h0800;

  typedef struct packed {
    logic            sign;
    logic [EMSB:0]   exp;
    logic [FMSB:0]   sig;
  } FP16N;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        nan;
  } FP16U;

endpackage

// File: rtl/fp_normalize16_pipe_if.sv
// Operand/result handshake bundle for the FP16 normalizer.
interface fp_normalize16_pipe_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_sig;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] o;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, in_nan, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, in_nan, out_ready,
    output in_ready, out_valid, o
  );

endinterface

// File: rtl/fp_normalize16_pipe_cntlz24.sv
// Combinational leading-zero counter over 24 bits; an all-zero word reports 23
// so callers that force bit 0 high never see an out-of-range count.
module cntlz24 (
  input  logic [23:0] a,
  output logic [4:0]  lz
);

  logic found;

  always_comb begin
    lz    = 5'd23;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && a[i]) begin
        lz    = 5'(23 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_normalize16_pipe.sv
// Three-stage FP16 normalizer: leading-zero count, sticky-preserving shift,
// then exponent adjust / special-case mapping into the FP16N result word.
module fp_normalize16_pipe
  import fp16Pkg::*;
#(
  parameter int unsigned SIG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_exp,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [18:0]      o
);

  localparam int unsigned WIDE_W = 2 * SIG_W - 1;
  localparam logic signed [9:0] EXP_OVF = 10'(2 * BIAS + 1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: classify and count leading zeros ----------------
  FP16U       in_op;
  logic [4:0] lz_c;

  assign in_op = '{sign: in_sign, exp: in_exp, sig: in_sig, nan: in_nan};

  cntlz24 u_cntlz (
    .a  ({in_sig[SIG_W-2:0], 1'b1}),
    .lz (lz_c)
  );

  logic       v1;
  FP16U       s1_op;
  logic [4:0] s1_lz;
  logic       s1_zero;
  logic       s1_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      s1_op    <= '0;
      s1_lz    <= '0;
      s1_zero  <= 1'b0;
      s1_carry <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_op    <= in_op;
        s1_lz    <= lz_c;
        s1_zero  <= (in_sig == '0);
        s1_carry <= in_sig[SIG_W-1];
      end
    end
  end

  // ---------------- S2: align significand, collect sticky ----------------
  logic signed [9:0] e_ext;
  logic signed [9:0] d_c;
  logic [4:0]        rsh_c;
  logic [4:0]        lsh_c;
  logic [WIDE_W-1:0] wide_c;
  logic signed [9:0] exp2_c;
  logic [2*SIG_W-1:0] frame;

  assign e_ext = $signed({{2{s1_op.exp[7]}}, s1_op.exp});
  assign d_c   = e_ext - $signed({5'b0, s1_lz});
  assign rsh_c = (e_ext < -10'sd23) ? 5'd24 : 5'(10'sd1 - e_ext);
  assign lsh_c = 5'(e_ext - 10'sd1);
  assign frame = {s1_op.sig, {SIG_W{1'b0}}};

  // Carry is only taken when the bumped exponent stays normal; a negative
  // exponent with carry falls into the subnormal right shift instead.
  always_comb begin
    wide_c = '0;
    exp2_c = '0;
    if (s1_carry && !s1_op.exp[7]) begin
      wide_c = WIDE_W'(frame >> 1);
      exp2_c = e_ext + 10'sd1;
    end else if (e_ext < 10'sd1) begin
      wide_c = WIDE_W'(frame >> rsh_c);
    end else if (d_c >= 10'sd1) begin
      wide_c = WIDE_W'(frame << s1_lz);
      exp2_c = d_c;
    end else begin
      wide_c = WIDE_W'(frame << lsh_c);
    end
  end

  logic              v2;
  logic              s2_sign;
  logic              s2_nan;
  logic              s2_zero;
  logic signed [9:0] s2_exp;
  logic [22:0]       s2_sig;
  logic              s2_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2        <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_exp    <= '0;
      s2_sig    <= '0;
      s2_sticky <= 1'b0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        s2_sign   <= s1_op.sign;
        s2_nan    <= s1_op.nan;
        s2_zero   <= s1_zero;
        s2_exp    <= exp2_c;
        s2_sig    <= wide_c[WIDE_W-1:SIG_W];
        s2_sticky <= |wide_c[SIG_W-1:0];
      end
    end
  end

  // ---------------- S3: specials, overflow, field select ----------------
  FP16N o_c;
  FP16N o_q;

  always_comb begin
    o_c = '0;
    if (s2_nan) begin
      o_c.exp = EXP_MAX;
      o_c.sig = QNAN_SIG;
    end else if (s2_zero) begin
      o_c.sign = s2_sign;
    end else if (s2_exp >= EXP_OVF) begin
      o_c.sign = s2_sign;
      o_c.exp  = EXP_MAX;
    end else begin
      o_c.sign   = s2_sign;
      o_c.exp    = 5'(s2_exp);
      o_c.sig    = s2_sig[22:10];
      o_c.sig[0] = s2_sig[10] | s2_sticky | (|s2_sig[9:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      o_q       <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        o_q <= o_c;
      end
    end
  end

  assign o = o_q;

endmodule

// File: tb/tb_fp_normalize16_pipe.sv
// Randomized and directed bench for fp_normalize16_pipe against a value-level
// normalization model and an in-order result scoreboard.
module tb_fp_normalize16_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_normalize16_pipe_if bus ();

  fp_normalize16_pipe #(.SIG_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_sign   (bus.in_sign),
    .in_exp    (bus.in_exp),
    .in_sig    (bus.in_sig),
    .in_nan    (bus.in_nan),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .o         (bus.o)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [18:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [18:0] prev_o = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Value-level reference: place the MSB, derive the unbiased exponent, then
  // scale the significand by 2^(in_exp - final_exp) with sticky on lost bits.
  function automatic logic [18:0] ref_norm(input logic s, input logic signed [7:0] e,
                                           input logic [23:0] m, input logic n);
    int          p, ue, ef, sh;
    logic [63:0] a;
    logic        stk;
    logic [12:0] f;
    if (n) return {1'b0, 5'd31, 13'h0800};
    if (m == 24'd0) return {s, 5'd0, 13'd0};
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    ue = int'(e) + p - 22;
    if (ue >= 31) return {s, 5'd31, 13'd0};
    ef  = (ue >= 1) ? ue : 1;
    sh  = int'(e) - ef;
    a   = 64'(m) << 24;
    stk = 1'b0;
    if (sh >= 0) a = a << sh;
    else if (-sh >= 48) begin
      stk = 1'b1;
      a   = '0;
    end else begin
      stk = |(a & ((64'd1 << (-sh)) - 64'd1));
      a   = a >> (-sh);
    end
    f    = a[46:34];
    f[0] = f[0] | stk | (|a[33:0]);
    return {s, (ue >= 1) ? 5'(ue) : 5'd0, f};
  endfunction

  // One cycle: drive at negedge, settle, score hand-off/accept for the next edge.
  task automatic step(input logic v, input logic s, input logic [7:0] e, input logic [23:0] m,
                      input logic n, input logic r, output logic acc);
    logic [18:0] want;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_sig    = m;
    bus.in_nan    = n;
    bus.out_ready = r;
    #1;
    if (bus.out_valid && prev_stall) chk("hold_o", 32'(bus.o), 32'(prev_o));
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_o     = bus.o;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("result", 32'(bus.o), 32'(want));
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(ref_norm(s, e, m, n));
  endtask

  task automatic run_one(input string tag, input logic s, input logic [7:0] e,
                         input logic [23:0] m, input logic n, input logic [18:0] want);
    logic        acc;
    logic [18:0] got;
    int          lat;
    got = 19'h7ffff;
    lat = 99;
    step(1'b1, s, e, m, n, 1'b1, acc);
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b1, acc);
      if (bus.out_valid) begin
        got = bus.o;
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk(tag, 32'(got), 32'(want));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, r, v, s, n;
    logic [7:0]  e;
    logic [23:0] m;
    logic [23:0] bsig[5];
    int          idx, cyc, n0, k;
    logic        saw;

    bus.in_valid = 0; bus.in_sign = 0; bus.in_exp = '0;
    bus.in_sig = '0; bus.in_nan = 0; bus.out_ready = 1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_o", 32'(bus.o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_one("one",      1'b0, 8'd15,  24'h400000, 1'b0, {1'b0, 5'd15, 13'h1000});
    run_one("carry",    1'b0, 8'd15,  24'h800001, 1'b0, {1'b0, 5'd16, 13'h1001});
    run_one("denorm1",  1'b0, 8'd1,   24'h100000, 1'b0, {1'b0, 5'd0,  13'h0400});
    run_one("denorm2",  1'b0, 8'hE2,  24'h400000, 1'b0, {1'b0, 5'd0,  13'h0001});
    run_one("ovf",      1'b0, 8'd31,  24'h400000, 1'b0, {1'b0, 5'd31, 13'h0000});
    run_one("nan",      1'b1, 8'd3,   24'h123456, 1'b1, {1'b0, 5'd31, 13'h0800});
    run_one("zero",     1'b1, 8'd20,  24'h000000, 1'b0, {1'b1, 5'd0,  13'h0000});
    run_one("min_norm", 1'b1, 8'd3,   24'h100000, 1'b0, {1'b1, 5'd1,  13'h1000});
    run_one("edge_den", 1'b0, 8'd2,   24'h100000, 1'b0, {1'b0, 5'd0,  13'h0800});
    run_one("carry_of", 1'b0, 8'd30,  24'h800000, 1'b0, {1'b0, 5'd31, 13'h0000});

    // Backpressure: five back-to-back operands, out_ready low for four cycles.
    for (int i = 0; i < 5; i++) bsig[i] = 24'h400000 | 24'($urandom_range(0, 24'h3fffff));
    idx = 0; cyc = 0; saw = 1'b0; n0 = n_out;
    while (cyc < 40 && (idx < 5 || exp_q.size() != 0)) begin
      r = !(cyc >= 3 && cyc < 7);
      m = (idx < 5) ? bsig[idx] : 24'd0;
      step(idx < 5, 1'b0, 8'd15, m, 1'b0, r, acc);
      if (!bus.in_ready) saw = 1'b1;
      if (acc) idx++;
      cyc++;
    end
    chk("bp_in_ready_fell", 32'(saw), 32'd1);
    chk("bp_count", 32'(n_out - n0), 32'd5);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two operands in flight.
    step(1'b1, 1'b0, 8'd15, 24'h400000, 1'b0, 1'b1, acc);
    step(1'b1, 1'b1, 8'd10, 24'h0f0000, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 8'd0,  24'd0,      1'b0, 1'b0, acc);
    @(negedge clk);
    chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b1, acc);
    chk("rst_no_stale", 32'(n_out - n0), 32'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 19));
      n = (k == 0);
      m = (k == 1) ? 24'd0 : (24'($urandom) >> $urandom_range(0, 23));
      e = (k < 14) ? 8'($urandom_range(0, 70) - 30) : 8'($urandom);
      s = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      step(v, s, e, m, n, r, acc);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      step(1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b1, acc);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_normalize16_pipe.md
FP_NORMALIZE16_PIPE -- requirements
Module: fp_normalize16_pipe

Interface
REQ-001 SHALL have parameter SIG_W, default 24, meaning raw significand width; only 24 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  an input operand is present.
REQ-005 SHALL have port in_ready  output  1  the stage accepts an operand this cycle.
REQ-006 SHALL have port in_sign  input  1  result sign.
REQ-007 SHALL have port in_exp  input  8  signed two's-complement biased exponent (bias 15).
REQ-008 SHALL have port in_sig  input  24  raw magnitude: bit 23 is the carry bit, binary point below bit 22.
REQ-009 SHALL have port in_nan  input  1  result is NaN; sign and significand are ignored.
REQ-010 SHALL have port out_valid  output  1  o holds a valid result.
REQ-011 SHALL have port out_ready  input  1  the downstream rounding stage accepts o.
REQ-012 SHALL have port o  output  19  FP16N: sign[18], exp[17:13], sig[12:0]; sig[12] is the leading bit, sig[2:0] is G/R/S, sig[0] is sticky.

Function
REQ-013 SHALL be a 3-stage pipeline with latency exactly 3 cycles from the accepting edge to out_valid when there are no stalls.
- S1: zero detect, carry detect, leading-zero count lz of in_sig[22:0].
- S2: barrel shift with sticky collection.
- S3: exponent adjust, special cases, output register.
REQ-014 SHALL transfer an operand when in_valid & in_ready, and SHALL hand off a result when out_valid & out_ready.
REQ-015 SHALL drive in_ready = !out_valid | out_ready, so a stall freezes all three stages together.
REQ-016 SHALL hold o and out_valid stable while out_valid & !out_ready.
REQ-017 SHALL carry bubbles through the pipeline as invalid stages, and SHALL allow accept and hand-off in the same cycle.
REQ-018 SHALL map a zero operand (in_sig == 0, !in_nan) to exp 0, sig 0, sign preserved.
REQ-019 SHALL handle a carry (in_sig[23] = 1) by shifting right 1 and setting exp = in_exp + 1; the bit shifted out ORs into sticky.
REQ-020 SHALL normalize when in_exp - lz >= 1: shift left by lz and set exp = in_exp - lz.
REQ-021 SHALL produce a denormal when in_exp - lz < 1 and in_exp >= 1: shift left by in_exp - 1 and set exp = 0.
REQ-022 SHALL handle in_exp < 1 by shifting right by 1 - in_exp, capped at 24; all shifted-out bits OR into sticky, and exp = 0.
REQ-023 SHALL select the field as sig[12:0] = shifted[22:10], with sig[0] |= OR of shifted[9:0] and any prior sticky.
REQ-024 SHALL map a final exp >= 31 (including from the carry path) to infinity: exp 31, sig 0.
REQ-025 SHALL map in_nan to exp 31, sig 13'h0800 (quiet), sign 0.
REQ-026 SHALL use signed arithmetic of at least 9 bits for exponent calculations; there is no wrap-around.

Reset
REQ-027 SHALL, while rst is asserted, clear out_valid and all stage valids to 0, clear o to 0, and drive in_ready to 1.
REQ-028 SHALL discard any operands in flight when rst is asserted mid-operation; no result emerges for them after reset is released.

Structure
REQ-029 SHALL take FP16N, EMSB, FMSB and the bias constant from fp16Pkg.
REQ-030 SHALL add a new typedef FP16U (sign, exp[7:0], sig[23:0], nan) to fp16Pkg.
REQ-031 SHALL instantiate one sub-module, cntlz24: a combinational leading-zero counter that returns 0..23.

Verification
REQ-032 SHALL cover exact 1.0: in_exp=15, in_sig=24'h400000 -> after 3 cycles o={0,5'd15,13'h1000}.
REQ-033 SHALL cover the carry case: in_exp=15, in_sig=24'h800001 -> exp 16, sig 13'h1001 (sticky set).
REQ-034 SHALL cover a denormal: in_exp=1, in_sig=24'h100000 -> exp 0, sig 13'h0400; and in_exp=-30, in_sig=24'h400000 -> exp 0, sig 13'h0001.
REQ-035 SHALL cover overflow: in_exp=31, in_sig=24'h400000 -> exp 31, sig 0; and in_nan=1 -> exp 31, sig 13'h0800.
REQ-036 SHALL cover backpressure: stream 5 back-to-back operands, hold out_ready low for 4 cycles -> in_ready falls, o is stable, and all 5 results emerge in order with none lost or duplicated.
REQ-037 SHALL cover reset mid-stream: assert rst with 2 operands in flight -> out_valid is 0 immediately, and no stale result appears after release.
